// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared MIPS definitions used by the fetch controller: state encoding and
// instruction-register geometry.
package instr_fetch_ctrl_pkg;

    localparam int unsigned IR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LAST  = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Multi-cycle instruction fetch from a byte-wide memory: reads four bytes
// little-endian into the instruction register, then pulses fetch_en_o and advances the PC.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int unsigned            ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  start_i,
    input  logic                  pc_load_i,
    input  logic [ADDR_W-1:0]     pc_next_i,
    output logic                  mem_rd_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    input  logic                  mem_ready_i,
    input  logic [7:0]            mem_rdata_i,
    output logic [7:0]            instr8bit_o,
    output logic [IR_BYTES-1:0]   IRWrite_o,
    output logic                  fetch_en_o,
    output logic [ADDR_W-1:0]     pc_o,
    output logic                  busy_o
);

    fetch_state_t          state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic                  mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [7:0]            instr_q, instr_d;
    logic [IR_BYTES-1:0]   ir_write_q, ir_write_d;
    logic                  fetch_en_q, fetch_en_d;
    logic                  busy_q, busy_d;

    // Target low bits are dropped: the PC is always word aligned.
    logic unused_pc_bits;
    assign unused_pc_bits = ^pc_next_i[1:0];

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            pc_q       <= RESET_PC;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            instr_q    <= 8'd0;
            ir_write_q <= '0;
            fetch_en_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
            ir_write_q <= ir_write_d;
            fetch_en_q <= fetch_en_d;
            busy_q     <= busy_d;
        end
    end

    // Next state; outputs are derived from the next state so they line up
    // with the state they describe once registered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        ir_write_d = '0;

        case (state_q)
            IDLE: begin
                if (pc_load_i) begin
                    pc_d = {pc_next_i[ADDR_W-1:2], 2'b00};
                end
                if (start_i) begin
                    state_d = FETCH;
                    cnt_d   = 2'd0;
                end
            end
            FETCH: begin
                if (mem_ready_i) begin
                    instr_d    = mem_rdata_i;
                    ir_write_d = IR_BYTES'(1) << cnt_q;
                    if (cnt_q == 2'd3) begin
                        state_d = LAST;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            LAST: begin
                state_d = DONE;
            end
            DONE: begin
                pc_d    = pc_q + ADDR_W'(IR_BYTES);
                cnt_d   = 2'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase

        mem_rd_d   = (state_d == FETCH);
        mem_addr_d = mem_rd_d ? (pc_d + ADDR_W'(cnt_d)) : '0;
        fetch_en_d = (state_d == DONE);
        busy_d     = (state_d != IDLE);
    end

    assign mem_rd_o    = mem_rd_q;
    assign mem_addr_o  = mem_addr_q;
    assign instr8bit_o = instr_q;
    assign IRWrite_o   = ir_write_q;
    assign fetch_en_o  = fetch_en_q;
    assign pc_o        = pc_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: 32-bit instance for fetch sequencing,
// 8-bit instance for PC wrap.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        srst;
    logic        start, pc_load, ready;
    logic [31:0] pc_next;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [7:0]  instr;
    logic [3:0]  ir_write;
    logic        fetch_en;
    logic [31:0] pc;
    logic        busy;

    logic        s_start, s_load;
    logic [7:0]  s_next;
    logic        s_rd;
    logic [7:0]  s_addr;
    logic [7:0]  s_instr;
    logic [3:0]  s_ir;
    logic        s_fen;
    logic [7:0]  s_pc;
    logic        s_busy;

    logic [7:0]  mem [256];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:0]];

    instr_fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk_i(clk), .srst_i(srst), .start_i(start), .pc_load_i(pc_load),
        .pc_next_i(pc_next), .mem_rd_o(mem_rd), .mem_addr_o(mem_addr),
        .mem_ready_i(ready), .mem_rdata_i(mem_rdata), .instr8bit_o(instr),
        .IRWrite_o(ir_write), .fetch_en_o(fetch_en), .pc_o(pc), .busy_o(busy)
    );

    instr_fetch_ctrl #(.ADDR_W(8), .RESET_PC(8'h0)) dut8 (
        .clk_i(clk), .srst_i(srst), .start_i(s_start), .pc_load_i(s_load),
        .pc_next_i(s_next), .mem_rd_o(s_rd), .mem_addr_o(s_addr),
        .mem_ready_i(1'b1), .mem_rdata_i(8'h5A), .instr8bit_o(s_instr),
        .IRWrite_o(s_ir), .fetch_en_o(s_fen), .pc_o(s_pc), .busy_o(s_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full fetch with ready=1; optionally load+start in cycle 0, or inject
    // an (ignored) load+start in cycle inj.
    task automatic do_fetch(input logic [31:0] base, input bit do_load, input logic [31:0] tgt,
                            input bit chk_data, input logic [31:0] word, input int inj);
        start = 1'b1;
        if (do_load) begin
            pc_load = 1'b1;
            pc_next = tgt;
        end
        tick();
        start   = 1'b0;
        pc_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("fetch_rd", 32'(mem_rd), 32'd1);
            check("fetch_addr", mem_addr, base + 32'(i));
            check("fetch_ir", 32'(ir_write), (i == 0) ? 32'd0 : (32'd1 << (i - 1)));
            if (chk_data && i > 0) check("fetch_data", 32'(instr), 32'(word[8*(i-1) +: 8]));
            if (inj == i + 1) begin
                pc_load = 1'b1;
                start   = 1'b1;
                pc_next = 32'h40;
            end
            tick();
            pc_load = 1'b0;
            start   = 1'b0;
        end
        check("last_ir", 32'(ir_write), 32'h8);
        if (chk_data) check("last_data", 32'(instr), 32'(word[31:24]));
        check("last_rd", 32'(mem_rd), 32'd0);
        check("last_fen", 32'(fetch_en), 32'd0);
        tick();
        check("done_fen", 32'(fetch_en), 32'd1);
        check("done_ir", 32'(ir_write), 32'd0);
        tick();
        check("next_pc", pc, base + 32'd4);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fen_cyc;
        bit seen;
        logic [31:0] w1, w2;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        mem[4] = 8'h55; mem[5] = 8'h66; mem[6] = 8'h77; mem[7] = 8'h88;
        w1 = 32'h44332211;
        w2 = 32'h88776655;
        srst = 1'b1; start = 1'b0; pc_load = 1'b0; pc_next = 32'h0; ready = 1'b1;
        s_start = 1'b0; s_load = 1'b0; s_next = 8'h0;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd", 32'(mem_rd), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_ir", 32'(ir_write), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_fen", 32'(fetch_en), 32'd0);
        srst = 1'b0;
        tick();

        // Back-to-back fetches of 11..44 and 55..88.
        do_fetch(32'h0, 1'b0, 32'h0, 1'b1, w1, 0);
        check("b2b_pc1", pc, 32'h4);
        do_fetch(32'h4, 1'b0, 32'h0, 1'b1, w2, 0);
        check("idle_hold_instr", 32'(instr), 32'h88);

        // Three wait cycles on byte 2; fetch_en expected in cycle 9.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        ready = 1'b0;
        check("wait_lane1", 32'(ir_write), 32'h2);
        for (int w = 0; w < 3; w++) begin
            check("wait_addr", mem_addr, 32'hA);
            check("wait_rd", 32'(mem_rd), 32'd1);
            if (w > 0) check("wait_ir", 32'(ir_write), 32'd0);
            tick();
        end
        ready = 1'b1;
        fen_cyc = 6;
        while (fetch_en !== 1'b1 && fen_cyc < 30) begin
            tick();
            fen_cyc++;
        end
        check("wait_fen_cycle", 32'(fen_cyc), 32'd9);
        tick();
        check("wait_pc", pc, 32'hC);

        // Load and start together: fetch uses the aligned target.
        do_fetch(32'h100, 1'b1, 32'h103, 1'b0, 32'h0, 0);

        // Reset after the lane-1 strobe abandons the fetch.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("rst_mid_lane1", 32'(ir_write), 32'h2);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_rd", 32'(mem_rd), 32'd0);
        check("rst_mid_ir", 32'(ir_write), 32'd0);
        check("rst_mid_pc", pc, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (fetch_en === 1'b1 || ir_write !== 4'd0) seen = 1'b1;
            tick();
        end
        check("rst_mid_no_fen", 32'(seen), 32'd0);
        check("rst_mid_pc_hold", pc, 32'd0);

        // Load+start in cycle 3 of a fetch is ignored.
        do_fetch(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 3);
        tick();
        check("ign_pc", pc, 32'h4);
        check("ign_busy", 32'(busy), 32'd0);

        // 8-bit PC wrap from 0xFC.
        s_load = 1'b1; s_next = 8'hFC; s_start = 1'b1;
        tick();
        s_load = 1'b0; s_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("wrap_addr", 32'(s_addr), 32'(8'hFC + 8'(i)));
            tick();
        end
        tick();
        check("wrap_fen", 32'(s_fen), 32'd1);
        tick();
        check("wrap_pc", 32'(s_pc), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
